// File: rtl/fifo_rr_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rr_write_arbiter
// Brief    : Round-robin arbiter sharing one FIFO write port among NUM_REQ
//            valid/ready producers, with bounded bursts and a word counter.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rr_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_w_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic                          grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic [CNT_WIDTH-1:0]          word_count
);

    localparam int c_ID_W    = $clog2(NUM_REQ);
    localparam int c_BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [c_BURST_W-1:0] c_LAST_BEAT = c_BURST_W'(MAX_BURST - 1);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_GRANT = 1'b1;

    logic [0:0]           r_state;
    logic [c_ID_W-1:0]    r_rr_ptr;
    logic [c_ID_W-1:0]    r_grant_id;
    logic [c_BURST_W-1:0] r_burst_cnt;
    logic [CNT_WIDTH-1:0] r_word_count;

    logic                 w_grant_st;
    logic                 w_cur_valid;
    logic                 w_xfer;
    logic                 w_release;
    logic                 w_sel_valid;
    logic [c_ID_W-1:0]    w_sel_id;
    logic [c_ID_W-1:0]    w_idx;
    logic [c_ID_W-1:0]    w_next_ptr;
    logic                 w_cnt_sat;

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_id    = '0;
        w_idx       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = c_ID_W'((32'(r_rr_ptr) + 32'(k)) % 32'(NUM_REQ));
            if (req_valid[w_idx]) begin
                w_sel_valid = 1'b1;
                w_sel_id    = w_idx;
            end
        end
    end

    assign w_grant_st  = (r_state == c_GRANT);
    assign w_cur_valid = req_valid[r_grant_id];
    assign w_xfer      = w_grant_st && w_cur_valid && !fifo_full;
    // A stalled (full) cycle never releases, even if the owner has dropped valid.
    assign w_release   = w_grant_st && !fifo_full &&
                         (!w_cur_valid || (r_burst_cnt == c_LAST_BEAT));
    assign w_next_ptr  = (r_grant_id == c_ID_W'(NUM_REQ - 1)) ? '0
                                                              : r_grant_id + 1'b1;
    assign w_cnt_sat   = &r_word_count;

    always_comb begin
        req_ready = '0;
        if (w_grant_st && !fifo_full) begin
            req_ready[r_grant_id] = 1'b1;
        end
    end

    assign fifo_w_en    = w_xfer;
    assign fifo_data_in = w_grant_st ? req_data[r_grant_id*DATA_WIDTH +: DATA_WIDTH]
                                     : '0;
    assign grant_valid  = w_grant_st;
    assign grant_id     = r_grant_id;
    assign word_count   = r_word_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= c_IDLE;
            r_rr_ptr     <= '0;
            r_grant_id   <= '0;
            r_burst_cnt  <= '0;
            r_word_count <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_sel_valid) begin
                        r_grant_id  <= w_sel_id;
                        r_burst_cnt <= '0;
                        r_state     <= c_GRANT;
                    end
                end
                c_GRANT: begin
                    if (w_release) begin
                        r_rr_ptr    <= w_next_ptr;
                        r_burst_cnt <= '0;
                        r_state     <= c_IDLE;
                    end else if (w_xfer) begin
                        r_burst_cnt <= r_burst_cnt + 1'b1;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
            if (w_xfer && !w_cnt_sat) begin
                r_word_count <= r_word_count + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_rr_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_rr_write_arbiter
// Brief    : Directed self-checking bench with a per-cycle behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_rr_write_arbiter;

    localparam int NR   = 4;
    localparam int DW   = 8;
    localparam int MB   = 4;
    localparam int CW   = 16;
    localparam int CMAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NR-1:0]   req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]   req_ready;
    logic            fifo_full;
    logic            fifo_w_en;
    logic [DW-1:0]   fifo_data_in;
    logic            grant_valid;
    logic [1:0]      grant_id;
    logic [CW-1:0]   word_count;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DW-1:0] qmem [NR][32];
    int            qhead [NR];
    int            qtail [NR];

    logic [DW-1:0] wlog [256];
    int            wlog_n = 0;
    int            glog [64];
    int            glog_n = 0;

    bit m_g     = 1'b0;
    int m_id    = 0;
    int m_burst = 0;
    int m_ptr   = 0;
    int m_cnt   = 0;

    int wb;
    int gb;

    fifo_rr_write_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_w_en    (fifo_w_en),
        .fifo_data_in (fifo_data_in),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id),
        .word_count   (word_count)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Producers: each requester offers the head of its word list while non-empty.
    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req_valid[i]         = (qhead[i] < qtail[i]);
            req_data[i*DW +: DW] = (qhead[i] < qtail[i]) ? qmem[i][qhead[i]] : '0;
        end
    endtask

    task automatic push(input int r, input logic [DW-1:0] v);
        qmem[r][qtail[r]] = v;
        qtail[r]++;
    endtask

    function automatic bit all_empty();
        bit e = 1'b1;
        for (int i = 0; i < NR; i++) if (qhead[i] < qtail[i]) e = 1'b0;
        return e;
    endfunction

    // One clock cycle; optionally pulses reset low between the edges.
    task automatic tick(input bit pulse);
        logic [NR-1:0] xfer;
        @(negedge clk);
        #1; if (pulse) rst = 1'b0;
        #1;
        if (pulse) begin
            check("pulse_w_en", fifo_w_en, 0);
            check("pulse_ready", req_ready, 0);
            check("pulse_count", word_count, 0);
        end
        #1; if (pulse) rst = 1'b1;
        #1; xfer = req_valid & req_ready;
        @(posedge clk); #1;
        for (int i = 0; i < NR; i++) if (xfer[i]) qhead[i]++;
        drive();
    endtask

    task automatic run_until_idle(input string name, input int bound);
        int n = 0;
        while (!(all_empty() && !grant_valid) && n < bound) begin
            tick(1'b0);
            n++;
        end
        check(name, (all_empty() && !grant_valid) ? 1 : 0, 1);
    endtask

    task automatic do_reset();
        @(negedge clk); #1 rst = 1'b0;
        for (int i = 0; i < NR; i++) begin
            qhead[i] = 0;
            qtail[i] = 0;
        end
        fifo_full = 1'b0;
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        check("post_reset_count", word_count, 0);
    endtask

    // Behavioural model of the arbitration rules.
    task automatic mreset();
        m_g = 1'b0; m_id = 0; m_burst = 0; m_ptr = 0; m_cnt = 0;
    endtask

    task automatic model_step();
        bit found = 1'b0;
        int j;
        if (!m_g) begin
            for (int k = 0; k < NR; k++) begin
                j = (m_ptr + k) % NR;
                if (!found && req_valid[j]) begin
                    found = 1'b1;
                    m_id  = j;
                end
            end
            if (found) begin
                m_g     = 1'b1;
                m_burst = 0;
            end
        end else if (!fifo_full) begin
            if (req_valid[m_id]) begin
                if (m_cnt < CMAX) m_cnt++;
                m_burst++;
            end
            if (!req_valid[m_id] || m_burst == MB) begin
                m_g     = 1'b0;
                m_burst = 0;
                m_ptr   = (m_id + 1) % NR;
            end
        end
    endtask

    task automatic model_check();
        logic [NR-1:0] e_ready = '0;
        logic          e_wen   = 1'b0;
        logic [DW-1:0] e_data  = '0;
        if (m_g) begin
            e_data = req_data[m_id*DW +: DW];
            if (!fifo_full) begin
                e_ready[m_id] = 1'b1;
                e_wen         = req_valid[m_id];
            end
        end
        check("m_grant_valid", grant_valid, m_g);
        if (m_g) check("m_grant_id", grant_id, m_id);
        check("m_req_ready", req_ready, e_ready);
        check("m_fifo_w_en", fifo_w_en, e_wen);
        check("m_fifo_data", fifo_data_in, e_data);
        check("m_word_count", word_count, m_cnt);
    endtask

    task automatic model_loop();
        forever begin
            @(negedge clk);
            model_check();
            @(posedge clk or negedge rst);
            if (!rst) begin
                mreset();
                #1 model_check();
                @(posedge clk);
                if (rst) model_step();
                else     mreset();
            end else begin
                model_step();
            end
        end
    endtask

    // Records what the FIFO actually accepts and each new grant, just before the edge.
    task automatic log_loop();
        bit prev = 1'b0;
        forever begin
            @(negedge clk); #4;
            if (fifo_w_en) begin
                wlog[wlog_n] = fifo_data_in;
                wlog_n++;
            end
            if (grant_valid && !prev) begin
                glog[glog_n] = int'(grant_id);
                glog_n++;
            end
            prev = grant_valid;
        end
    endtask

    initial begin
        fifo_full = 1'b0;
        req_valid = '0;
        req_data  = '0;
        for (int i = 0; i < NR; i++) begin
            qhead[i] = 0;
            qtail[i] = 0;
        end
        fork
            model_loop();
            log_loop();
        join_none

        // Reset held with every requester valid
        for (int i = 0; i < NR; i++) push(i, DW'(8'hF0 + i));
        drive();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", req_ready, 0);
        check("rst_w_en", fifo_w_en, 0);
        check("rst_grant_valid", grant_valid, 0);
        check("rst_count", word_count, 0);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check("first_grant_valid", grant_valid, 1);
        check("first_grant_id", grant_id, 0);
        run_until_idle("t1_done", 40);
        for (int k = 0; k < NR; k++) check("t1_word", wlog[k], 8'hF0 + k);
        for (int k = 0; k < NR; k++) check("t1_grant", glog[k], k);
        check("t1_count", word_count, 4);

        // Single requester, 6 words: burst of 4 then re-grant for 2
        do_reset();
        wb = wlog_n; gb = glog_n;
        for (int w = 0; w < 6; w++) push(0, DW'(8'hA0 + w));
        drive();
        run_until_idle("t2_done", 40);
        check("t2_nwords", wlog_n - wb, 6);
        for (int k = 0; k < 6; k++) check("t2_word", wlog[wb + k], 8'hA0 + k);
        check("t2_ngrants", glog_n - gb, 2);
        check("t2_grant0", glog[gb], 0);
        check("t2_grant1", glog[gb + 1], 0);
        check("t2_count", word_count, 6);

        // Fairness: every requester holds 8 words
        do_reset();
        wb = wlog_n; gb = glog_n;
        for (int r = 0; r < NR; r++)
            for (int w = 0; w < 8; w++) push(r, DW'(r * 16 + w));
        drive();
        run_until_idle("t3_done", 120);
        check("t3_nwords", wlog_n - wb, 32);
        for (int k = 0; k < 32; k++)
            check("t3_word", wlog[wb + k], ((k / 4) % 4) * 16 + (k / 16) * 4 + (k % 4));
        check("t3_ngrants", glog_n - gb, 8);
        for (int k = 0; k < 8; k++) check("t3_grant", glog[gb + k], k % 4);
        check("t3_count", word_count, 32);

        // Backpressure on requester 1 after its 2nd word
        do_reset();
        wb = wlog_n; gb = glog_n;
        for (int w = 0; w < 4; w++) push(1, DW'(8'hB0 + w));
        drive();
        repeat (3) tick(1'b0);
        fifo_full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("t4_full_w_en", fifo_w_en, 0);
            check("t4_full_ready", req_ready, 0);
            check("t4_full_gid", grant_id, 1);
            check("t4_full_gvalid", grant_valid, 1);
            tick(1'b0);
        end
        fifo_full = 1'b0;
        run_until_idle("t4_done", 20);
        check("t4_nwords", wlog_n - wb, 4);
        for (int k = 0; k < 4; k++) check("t4_word", wlog[wb + k], 8'hB0 + k);
        check("t4_count", word_count, 4);
        gb = glog_n;
        push(0, 8'hC0);
        push(2, 8'hC2);
        drive();
        run_until_idle("t4b_done", 20);
        check("t4_next_grant", glog[gb], 2);
        check("t4_after_grant", glog[gb + 1], 0);

        // Early release: requester 2 runs dry after 2 words
        do_reset();
        wb = wlog_n; gb = glog_n;
        push(2, 8'hE0);
        push(2, 8'hE1);
        drive();
        tick(1'b0);
        push(0, 8'hD0); push(0, 8'hD1);
        push(3, 8'h30); push(3, 8'h31);
        drive();
        run_until_idle("t5_done", 40);
        check("t5_grant0", glog[gb], 2);
        check("t5_grant1", glog[gb + 1], 3);
        check("t5_grant2", glog[gb + 2], 0);
        check("t5_word0", wlog[wb], 8'hE0);
        check("t5_word2", wlog[wb + 2], 8'h30);
        check("t5_word5", wlog[wb + 5], 8'hD1);
        check("t5_count", word_count, 6);

        // Asynchronous reset during requester 3's 2nd word
        do_reset();
        wb = wlog_n; gb = glog_n;
        for (int w = 0; w < 4; w++) push(3, DW'(8'hC0 + w));
        drive();
        tick(1'b0);
        tick(1'b0);
        push(0, 8'h0A);
        drive();
        tick(1'b1);
        check("t6_regrant_valid", grant_valid, 1);
        check("t6_regrant_id", grant_id, 0);
        run_until_idle("t6_done", 40);
        check("t6_nwords", wlog_n - wb, 5);
        check("t6_word0", wlog[wb], 8'hC0);
        check("t6_word1", wlog[wb + 1], 8'h0A);
        check("t6_word2", wlog[wb + 2], 8'hC1);
        check("t6_count", word_count, 4);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_rr_write_arbiter.md
Name: fifo_rr_write_arbiter

Overview:
Round-robin write-port arbiter that shares one synchronous FIFO's write side (w_en/data_in/full) among NUM_REQ producers. Each producer uses a valid/ready handshake. A granted producer may hold the FIFO for a burst of up to MAX_BURST words, then priority rotates to the next producer. The block sits between the producer blocks and the FIFO instance and also keeps a saturating count of words written.

Parameters:
NUM_REQ, 4, number of requesters (legal values: 2 or more).
DATA_WIDTH, 8, FIFO word width.
MAX_BURST, 4, maximum number of words per grant (legal values: 1 or more).
CNT_WIDTH, 16, width of the word_count statistic.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  asynchronous reset, active-low.
req_valid  in  NUM_REQ  bit i set: requester i has a word ready.
req_data  in  NUM_REQ*DATA_WIDTH  requester i's word is on bits [i*DATA_WIDTH +: DATA_WIDTH].
req_ready  out  NUM_REQ  one-hot or zero; a word transfers when req_valid[i] and req_ready[i] are both high.
fifo_full  in  1  full flag from the FIFO.
fifo_w_en  out  1  write enable to the FIFO.
fifo_data_in  out  DATA_WIDTH  write data to the FIFO.
grant_valid  out  1  high while a requester holds the grant.
grant_id  out  $clog2(NUM_REQ)  index of the granted requester.
word_count  out  CNT_WIDTH  total words written; saturates at all-ones.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE; rr_ptr=0, grant_id=0, grant_valid=0, burst_cnt=0, word_count=0.
  - req_ready=0, fifo_w_en=0, fifo_data_in=0 immediately, without waiting for a clock edge.
- FSM with two states, IDLE and GRANT.
- IDLE:
  - If any req_valid bit is set, select the first set bit scanning from rr_ptr upward, wrapping modulo NUM_REQ.
  - Register grant_id with that index, set grant_valid=1, clear burst_cnt, and move to GRANT.
  - Arbitration latency is 1 cycle: there is no transfer in the IDLE cycle.
  - With no requests, stay in IDLE.
- GRANT, with g = grant_id:
  - req_ready[g] = !fifo_full; all other req_ready bits are 0.
  - fifo_w_en = req_valid[g] && !fifo_full. This is combinational from registered state and the inputs.
  - fifo_data_in = requester g's data slice while granted; 0 otherwise.
  - Each cycle with fifo_w_en high is one transfer: burst_cnt increments and word_count increments unless it is saturated.
- Grant release (GRANT to IDLE):
  - (a) A transfer occurs while burst_cnt == MAX_BURST-1; or
  - (b) req_valid[g] is low in a cycle with fifo_full low (the requester has gone idle).
  - On release: rr_ptr = (g+1) mod NUM_REQ, grant_valid=0, burst_cnt=0.
  - At least one IDLE bubble cycle always follows a release.
- fifo_full high during GRANT:
  - No transfer; grant, burst_cnt and rr_ptr are held.
  - No timeout: the stall lasts as long as fifo_full stays high.
  - req_valid[g] dropping while full is not a release; it is re-evaluated once full clears.
- Only the granted requester is ever served. Other requesters must hold req_valid and req_data stable until they are served (AXI-style; the arbiter does not check this).
- fifo_w_en is never asserted while fifo_full is high, so the FIFO never sees an overflow write.
- Reset during a burst: a word presented in that cycle is not written, because w_en is forced to 0. After reset, arbitration restarts from requester 0.

Test Plan:
- Reset: hold rst=0 with all req_valid=1 → req_ready=0, fifo_w_en=0, grant_valid=0, word_count=0; after rst=1, the first grant is requester 0 one cycle later.
- Single requester: req_valid=4'b0001 with 6 words A0..A5, fifo_full=0 → A0..A3 written on consecutive cycles, 1 IDLE cycle, re-grant to 0, A4..A5 written, then release on valid drop; word_count=6; FIFO order A0..A5.
- Fairness: all 4 requesters continuously valid → grant sequence 0,1,2,3,0; each burst is exactly 4 writes, separated by 1 idle cycle; word_count=16 after the first full rotation.
- Backpressure: requester 1 granted, fifo_full=1 for 3 cycles after its 2nd word → fifo_w_en=0 and req_ready[1]=0 for 3 cycles; grant_id stays 1; exactly 2 more words are written after full clears, then rr_ptr=2.
- Early release: requester 2 drops valid after 2 words while 0 and 3 are valid → release after 2 writes; the next grant is 3, not 0.
- Async reset mid-burst: rst pulsed low between clock edges during requester 3's 2nd word → fifo_w_en drops immediately, word_count=0, and the next grant is requester 0.
